// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, imem handshake and IF/ID register.
// One-cycle fetch when imem_ready is high; a redirect seen while imem is busy is latched until the next accept.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        stall,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        redir;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    always_comb begin
        target_raw = bpc;
        case (pcsource)
            2'b10:   target_raw = rpc;
            2'b11:   target_raw = jpc;
            default: target_raw = bpc;
        endcase
    end

    assign redir    = (pcsource != 2'b00);
    assign target   = target_raw & ALIGN_MASK;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d         = pc_q;
        id_inst_d    = id_inst_q;
        id_pc4_d     = id_pc4_q;
        id_valid_d   = id_valid_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        // stall freezes everything; ID re-presents pcsource once it drops
        if (!stall) begin
            if (!imem_ready) begin
                id_inst_d  = 32'd0;
                id_pc4_d   = 32'd0;
                id_valid_d = 1'b0;
                if (redir) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = target;
                end
            end else begin
                if (redir) begin
                    pc_d = target;
                end else if (pend_valid_q) begin
                    pc_d = pend_pc_q;
                end else begin
                    pc_d = pc_plus4;
                end
                pend_valid_d = 1'b0;
                if (!DELAY_SLOT && (redir || pend_valid_q)) begin
                    id_inst_d  = 32'd0;
                    id_pc4_d   = 32'd0;
                    id_valid_d = 1'b0;
                end else begin
                    id_inst_d  = imem_rdata;
                    id_pc4_d   = pc_plus4;
                    id_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= PC_INIT;
            id_inst_q    <= 32'd0;
            id_pc4_q     <= 32'd0;
            id_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            id_inst_q    <= id_inst_d;
            id_pc4_q     <= id_pc4_d;
            id_valid_q   <= id_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench: three fetch units (delay slot, squash, wrapping reset PC) driven by one stimulus table.
module tb_pc_fetch_unit;

    localparam logic [31:0] K = 32'hDEAD_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0, rpc = 32'd0, jpc = 32'd0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;

    logic [31:0] addr0, pc0, inst0, pc40, rd0;
    logic [31:0] addr1, pc1, inst1, pc41, rd1;
    logic [31:0] addr2, pc2, inst2, pc42, rd2;
    logic        v0, v1, v2;

    // instruction memory: word at address A is A ^ K
    assign rd0 = addr0 ^ K;
    assign rd1 = addr1 ^ K;
    assign rd2 = addr2 ^ K;

    always #5 clock = ~clock;

    pc_fetch_unit u0 (
        .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .stall(stall), .imem_rdata(rd0), .imem_ready(imem_ready), .imem_addr(addr0),
        .pc(pc0), .id_inst(inst0), .id_pc4(pc40), .id_valid(v0));

    pc_fetch_unit #(.DELAY_SLOT(1'b0)) u1 (
        .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .stall(stall), .imem_rdata(rd1), .imem_ready(imem_ready), .imem_addr(addr1),
        .pc(pc1), .id_inst(inst1), .id_pc4(pc41), .id_valid(v1));

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u2 (
        .clock(clock), .reset(reset), .pcsource(pcsource), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .stall(stall), .imem_rdata(rd2), .imem_ready(imem_ready), .imem_addr(addr2),
        .pc(pc2), .id_inst(inst2), .id_pc4(pc42), .id_valid(v2));

    typedef struct {
        logic        st;
        logic        rdy;
        logic [1:0]  ps;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        v;
        logic        v_sq;
        logic        pend;
    } vec_t;

    vec_t vecs [23];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rdy, input logic [1:0] ps, input logic [31:0] tgt);
        stall      = st;
        imem_ready = rdy;
        pcsource   = ps;
        bpc        = tgt;
        rpc        = tgt;
        jpc        = tgt;
    endtask

    initial begin
        logic [31:0] e_inst;

        //              st    rdy   ps     tgt        pc         id_pc4     v     v_sq  pend
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h004, 32'h004, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h008, 32'h008, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 32'h040, 32'h040, 32'h00C, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h044, 32'h044, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 32'h010, 32'h010, 32'h048, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd3, 32'h080, 32'h010, 32'h048, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd3, 32'h080, 32'h010, 32'h048, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'h080, 32'h010, 32'h048, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 32'h080, 32'h080, 32'h014, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h022, 32'h020, 32'h084, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h103, 32'h020, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h000, 32'h020, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h100, 32'h024, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h180, 32'h100, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 32'h000, 32'h100, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'd3, 32'h200, 32'h100, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h200, 32'h104, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 2'd1, 32'h300, 32'h200, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 2'd3, 32'h400, 32'h200, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 2'd0, 32'h000, 32'h300, 32'h204, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 2'd1, 32'h500, 32'h300, 32'h000, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 2'd2, 32'h600, 32'h600, 32'h304, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 2'd1, 32'h700, 32'h600, 32'h000, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        chk("reset pc", pc0, 32'h0);
        chk("reset imem_addr", addr0, 32'h0);
        chk("reset id_inst", inst0, 32'h0);
        chk("reset id_pc4", pc40, 32'h0);
        chk("reset id_valid", {31'b0, v0}, 32'h0);
        chk("reset pc wrapcfg", pc2, 32'hFFFF_FFFC);

        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].st, vecs[i].rdy, vecs[i].ps, vecs[i].tgt);
            @(posedge clock);
            #1;
            e_inst = vecs[i].v ? ((vecs[i].pc4 - 32'd4) ^ K) : 32'd0;
            chk($sformatf("row%0d pc", i), pc0, vecs[i].pc);
            chk($sformatf("row%0d imem_addr", i), addr0, vecs[i].pc);
            chk($sformatf("row%0d id_pc4", i), pc40, vecs[i].pc4);
            chk($sformatf("row%0d id_inst", i), inst0, e_inst);
            chk($sformatf("row%0d id_valid", i), {31'b0, v0}, {31'b0, vecs[i].v});
            chk($sformatf("row%0d pend_valid", i), {31'b0, u0.pend_valid_q}, {31'b0, vecs[i].pend});
            chk($sformatf("row%0d squash pc", i), pc1, vecs[i].pc);
            chk($sformatf("row%0d squash id_valid", i), {31'b0, v1}, {31'b0, vecs[i].v_sq});
            chk($sformatf("row%0d squash id_inst", i), inst1, vecs[i].v_sq ? e_inst : 32'd0);
            chk($sformatf("row%0d squash id_pc4", i), pc41, vecs[i].v_sq ? vecs[i].pc4 : 32'd0);
            if (i == 0) begin
                chk("wrap pc", pc2, 32'h0);
                chk("wrap id_pc4", pc42, 32'h0);
                chk("wrap id_inst", inst2, 32'hFFFF_FFFC ^ K);
                chk("wrap id_valid", {31'b0, v2}, 32'h1);
            end
            if (i == 1) begin
                chk("wrap pc+1", pc2, 32'h4);
                chk("wrap id_pc4+1", pc42, 32'h4);
            end
        end

        // asynchronous reset mid-cycle with a redirect pending
        #2;
        reset = 1'b1;
        #1;
        chk("async pc", pc0, 32'h0);
        chk("async imem_addr", addr0, 32'h0);
        chk("async id_valid", {31'b0, v0}, 32'h0);
        chk("async id_pc4", pc40, 32'h0);
        chk("async id_inst", inst0, 32'h0);
        chk("async pend_valid", {31'b0, u0.pend_valid_q}, 32'h0);
        chk("async pc wrapcfg", pc2, 32'hFFFF_FFFC);

        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 1'b1, 2'd0, 32'h0);
        @(posedge clock);
        #1;
        chk("post-reset pc", pc0, 32'h4);
        chk("post-reset id_pc4", pc40, 32'h4);
        chk("post-reset id_inst", inst0, 32'h0 ^ K);
        chk("post-reset id_valid", {31'b0, v0}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
